lcd_cmd_seq: RTL
================

Name: lcd_cmd_seq

Overview:
- Host-side initiator for the LCD controller's command interface.
- Fetches a 4-bit opcode list from a command ROM and issues each opcode over cmd/cmd_valid, respecting busy. It ends the list with the Write opcode and waits for done.
- Also monitors the controller's IRAM write stream. It counts the writes, accumulates a checksum and flags address-order errors.
- Sits between the command ROM and the LCD controller inside the test/host subsystem.

Parameters:
- CMD_AW, 6, command ROM address width (depth 2**CMD_AW)
- TMO, 1023, cycles allowed in any wait state before timeout error

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins sequencing; honoured only in IDLE
- CMDROM_rd  out  1  command ROM read enable
- CMDROM_A  out  CMD_AW  command ROM address
- CMDROM_Q  in  4  opcode; valid the cycle after CMDROM_rd=1
- cmd  out  4  opcode to controller; held stable until the next issue
- cmd_valid  out  1  one-cycle issue strobe
- busy  in  1  controller busy
- done  in  1  controller finished writing
- IRAM_valid  in  1  controller write strobe
- IRAM_A  in  6  write address
- IRAM_D  in  8  write data
- wr_count  out  7  IRAM writes seen (0..64)
- checksum  out  16  modulo-2^16 sum of IRAM_D over valid writes
- seq_done  out  1  level, high in FINISH
- err  out  1  level, high in ERROR
- err_code  out  2  0 none, 1 timeout, 2 no Write opcode in list, 3 IRAM address out of order

Behaviour:
- Reset values: all outputs 0, ptr 0, state IDLE, timeout counter 0. A reset mid-sequence aborts immediately and returns to IDLE next edge.
- Opcodes: 0 is Write; 1-11 are valid controller commands; 12-15 are illegal.
- FSM states and transitions:
  - IDLE: start=1 -> FETCH with ptr=0.
  - FETCH (1 cycle): CMDROM_rd=1, CMDROM_A=ptr -> LATCH.
  - LATCH (1 cycle): op<=CMDROM_Q.
    - If op is 12-15: the opcode is skipped, not issued. ptr+1 -> FETCH; if ptr==2**CMD_AW-1 -> ERROR code 2.
    - Otherwise -> READY.
  - READY: wait busy==0, then -> ISSUE. This covers the 64-cycle image load before the first command.
  - ISSUE (1 cycle): registered cmd<=op and cmd_valid<=1, so both are visible the following cycle.
  - GUARD (1 cycle): cmd_valid drops to 0.
    - op==0 -> WAIT_DONE.
    - Otherwise -> WAIT_BUSY. busy may still read 0 in the issue cycle; GUARD masks it.
  - WAIT_BUSY: busy==0 -> ptr+1 -> FETCH; if ptr==2**CMD_AW-1 -> ERROR code 2.
  - WAIT_DONE: done==1 -> FINISH.
  - FINISH and ERROR are absorbing until reset.
- Timeout: a counter clears on entry to READY, WAIT_BUSY and WAIT_DONE and increments each cycle in them. Reaching TMO -> ERROR code 1.
- cmd keeps its last value after cmd_valid drops. The controller samples cmd during execution, so it must not change.
- IRAM monitor runs in every state except IDLE:
  - On IRAM_valid=1: wr_count+1 (saturates at 64), checksum+=IRAM_D.
  - If IRAM_A != wr_count[5:0] -> ERROR code 3, only if not already in ERROR. The error takes priority over a simultaneous done.
- Errors never overwrite an existing err_code; the first error wins.

Decomposition:
- Shared package lcd_pkg holds:
  - opcode constants OP_WRITE=0, OP_UP=1, OP_DOWN=2, OP_LEFT=3, OP_RIGHT=4, OP_MAX=5, OP_MIN=6, OP_AVG=7, OP_CCW=8, OP_CW=9, OP_MIRX=10, OP_MIRY=11;
  - the err_code enum;
  - the IMG_PIXELS=64 constant.
- One natural sub-module: lcd_iram_mon, holding the wr_count/checksum/address check.

Test Plan:
- List {1,4,0}, busy high 64 cycles then 2-cycle pulses per command, then 64 IRAM writes with D=A -> three cmd_valid pulses carrying cmd 1, 4, 0 in order; wr_count=64; checksum=2016; seq_done=1; err=0.
- List {13,7,15,0} -> only opcodes 7 and 0 are issued; 13 and 15 never appear on cmd.
- List of 64 entries all 5 (no 0) -> after the 64th issue, ERROR with err_code=2.
- busy held high forever after reset -> err=1, err_code=1 exactly TMO cycles after entering READY.
- Write stream with IRAM_A sequence 0,1,3 -> err_code=3 on the third write; wr_count=3.
- Reset asserted during WAIT_BUSY -> all outputs 0 next cycle; a new start reruns the list from address 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcodes, error codes and sizes for the LCD host-side sequencer.
package lcd_pkg;

    localparam int IMG_PIXELS = 64;

    localparam logic [3:0] OP_WRITE = 4'd0;
    localparam logic [3:0] OP_UP    = 4'd1;
    localparam logic [3:0] OP_DOWN  = 4'd2;
    localparam logic [3:0] OP_LEFT  = 4'd3;
    localparam logic [3:0] OP_RIGHT = 4'd4;
    localparam logic [3:0] OP_MAX   = 4'd5;
    localparam logic [3:0] OP_MIN   = 4'd6;
    localparam logic [3:0] OP_AVG   = 4'd7;
    localparam logic [3:0] OP_CCW   = 4'd8;
    localparam logic [3:0] OP_CW    = 4'd9;
    localparam logic [3:0] OP_MIRX  = 4'd10;
    localparam logic [3:0] OP_MIRY  = 4'd11;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_TMO   = 2'd1,
        ERR_NOWR  = 2'd2,
        ERR_ORDER = 2'd3
    } err_code_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_MIRY;
    endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Command strobe and IRAM write stream between host sequencer and LCD controller.
interface lcd_cmd_seq_if;

    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;

    modport master (
        output cmd, cmd_valid,
        input  busy, done, IRAM_valid, IRAM_A, IRAM_D
    );

    modport slave (
        input  cmd, cmd_valid,
        output busy, done, IRAM_valid, IRAM_A, IRAM_D
    );

endinterface

// File: rtl/lcd_iram_mon.sv
// Watches the controller's IRAM writes: count, checksum, in-order addressing.
module lcd_iram_mon
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        valid,
    input  logic [5:0]  addr,
    input  logic [7:0]  data,
    output logic [6:0]  wr_count,
    output logic [15:0] checksum,
    output logic        addr_err
);

    localparam logic [6:0] MAX_WR = 7'(IMG_PIXELS);

    logic hit;

    assign hit      = active && valid;
    assign addr_err = hit && (addr != wr_count[5:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
            checksum <= '0;
        end else if (hit) begin
            if (wr_count != MAX_WR)
                wr_count <= wr_count + 1'b1;
            checksum <= checksum + {8'd0, data};
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Fetches opcodes from the command ROM and issues them to the LCD controller.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int CMD_AW = 6,
    parameter int TMO    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CMDROM_rd,
    output logic [CMD_AW-1:0] CMDROM_A,
    input  logic [3:0]        CMDROM_Q,
    lcd_cmd_seq_if.master     ctl,
    output logic [6:0]        wr_count,
    output logic [15:0]       checksum,
    output logic              seq_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TMO - 1);
    localparam logic [CMD_AW-1:0] PTR_LAST = '1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_LATCH     = 4'd2;
    localparam logic [3:0] S_READY     = 4'd3;
    localparam logic [3:0] S_ISSUE     = 4'd4;
    localparam logic [3:0] S_GUARD     = 4'd5;
    localparam logic [3:0] S_WAIT_BUSY = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;
    localparam logic [3:0] S_ERROR     = 4'd9;

    logic [3:0]        state;
    logic [CMD_AW-1:0] ptr;
    logic [3:0]        op;
    logic [TW-1:0]     tmo_cnt;
    err_code_t         ecode;
    logic              addr_err;
    logic              abort;
    logic              tmo_hit;

    assign CMDROM_rd = (state == S_FETCH);
    assign CMDROM_A  = ptr;
    assign seq_done  = (state == S_FINISH);
    assign err       = (state == S_ERROR);
    assign err_code  = ecode;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    // A bad write address preempts whatever the FSM was about to do.
    assign abort     = addr_err && (state != S_ERROR) && (state != S_FINISH);

    lcd_iram_mon u_mon (
        .clk      (clk),
        .reset    (reset),
        .active   (state != S_IDLE),
        .valid    (ctl.IRAM_valid),
        .addr     (ctl.IRAM_A),
        .data     (ctl.IRAM_D),
        .wr_count (wr_count),
        .checksum (checksum),
        .addr_err (addr_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            op            <= '0;
            tmo_cnt       <= '0;
            ecode         <= ERR_NONE;
            ctl.cmd       <= '0;
            ctl.cmd_valid <= 1'b0;
        end else begin
            ctl.cmd_valid <= (state == S_ISSUE) && !abort;
            if ((state == S_ISSUE) && !abort)
                ctl.cmd <= op;
            if (abort) begin
                state <= S_ERROR;
                ecode <= ERR_ORDER;
            end else begin
                unique case (state)
                    S_IDLE: if (start) begin
                        ptr   <= '0;
                        state <= S_FETCH;
                    end
                    S_FETCH: state <= S_LATCH;
                    S_LATCH: begin
                        op <= CMDROM_Q;
                        if (!op_illegal(CMDROM_Q)) begin
                            tmo_cnt <= '0;
                            state   <= S_READY;
                        end else if (ptr == PTR_LAST) begin
                            state <= S_ERROR;
                            ecode <= ERR_NOWR;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_READY: begin
                        if (!ctl.busy) begin
                            state <= S_ISSUE;
                        end else if (tmo_hit) begin
                            state <= S_ERROR;
                            ecode <= ERR_TMO;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_ISSUE: state <= S_GUARD;
                    // busy may not have risen yet in the issue cycle.
                    S_GUARD: begin
                        tmo_cnt <= '0;
                        state   <= (op == OP_WRITE) ? S_WAIT_DONE
                                                    : S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        if (!ctl.busy) begin
                            if (ptr == PTR_LAST) begin
                                state <= S_ERROR;
                                ecode <= ERR_NOWR;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= S_FETCH;
                            end
                        end else if (tmo_hit) begin
                            state <= S_ERROR;
                            ecode <= ERR_TMO;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (ctl.done) begin
                            state <= S_FINISH;
                        end else if (tmo_hit) begin
                            state <= S_ERROR;
                            ecode <= ERR_TMO;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_FINISH: state <= S_FINISH;
                    S_ERROR:  state <= S_ERROR;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
